// File: rtl/mips_pkg.sv
// Shared MIPS-I encodings: opcodes, SPECIAL functs, exception codes and LateALU ops.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LWL      = 6'h22;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_LBU      = 6'h24;
  localparam logic [5:0] OP_LHU      = 6'h25;
  localparam logic [5:0] OP_LWR      = 6'h26;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SWL      = 6'h2A;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] OP_SWR      = 6'h2E;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;
  localparam logic [5:0] FN2_MUL    = 6'h02;

  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  typedef enum logic [2:0] {
    EXC_NONE    = 3'd0,
    EXC_OVF     = 3'd1,
    EXC_SYSCALL = 3'd2,
    EXC_BREAK   = 3'd3,
    EXC_RI      = 3'd4
  } exc_t;

  localparam logic [5:0] LA_NONE  = 6'h00;
  localparam logic [5:0] LA_MUL   = 6'h02;
  localparam logic [5:0] LA_MTHI  = 6'h11;
  localparam logic [5:0] LA_MTLO  = 6'h13;
  localparam logic [5:0] LA_MULT  = 6'h18;
  localparam logic [5:0] LA_MULTU = 6'h19;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR};
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Bundle between decode/bypass and the execute stage, plus the stage results.
interface alu_exec_stage_if;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rs_override_rd;
  logic        rt_override_rd;
  logic        const_override_rs;
  logic        const_override_rt;
  logic        br_late_done;
  logic [31:0] latealu_hi;
  logic [31:0] latealu_lo;

  logic [4:0]  rd_index;
  logic [31:0] rd_value;
  logic        br_late_enable;
  logic [31:0] br_late_target;
  logic        memop_disable;
  logic        early_exception_disable;
  logic        latealu_enable;
  logic [5:0]  latealu_op;
  logic [31:0] latealu_a0;
  logic [31:0] latealu_a1;
  logic [2:0]  exception;

  modport master (
    output inst, pc, rs_val, rt_val, rs_override_rd, rt_override_rd,
           const_override_rs, const_override_rt, br_late_done, latealu_hi, latealu_lo,
    input  rd_index, rd_value, br_late_enable, br_late_target, memop_disable,
           early_exception_disable, latealu_enable, latealu_op, latealu_a0, latealu_a1,
           exception
  );

  modport slave (
    input  inst, pc, rs_val, rt_val, rs_override_rd, rt_override_rd,
           const_override_rs, const_override_rt, br_late_done, latealu_hi, latealu_lo,
    output rd_index, rd_value, br_late_enable, br_late_target, memop_disable,
           early_exception_disable, latealu_enable, latealu_op, latealu_a0, latealu_a1,
           exception
  );
endinterface

// File: rtl/alu_branch_unit.sv
// Late branch resolution: conditional branch compare and JR/JALR redirect (combinational).
module alu_branch_unit
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rt_field,
  input  logic [15:0] imm,
  input  logic [31:0] pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken,
  output logic [31:0] target
);

  logic [31:0] imm_sext;
  logic [31:0] rel_target;
  logic        rs_zero;

  assign imm_sext   = sext16(imm);
  assign rel_target = pc + 32'd4 + {imm_sext[29:0], 2'b00};
  assign rs_zero    = (rs_val == 32'd0);

  always_comb begin
    taken  = 1'b0;
    target = rel_target;
    case (opcode)
      OP_BEQ:  taken = (rs_val == rt_val);
      OP_BNE:  taken = (rs_val != rt_val);
      OP_BLEZ: taken = rs_val[31] | rs_zero;
      OP_BGTZ: taken = ~rs_val[31] & ~rs_zero;
      OP_REGIMM: begin
        if (rt_field == RT_BLTZ) taken = rs_val[31];
        else if (rt_field == RT_BGEZ) taken = ~rs_val[31];
      end
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          taken  = 1'b1;
          target = rs_val;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// MIPS-I execute stage: integer ALU, address generation, late branches and LateALU dispatch.
module alu_exec_stage
  import mips_pkg::*;
#(
  parameter int unsigned RESET_PC_UNUSED = 0
) (
  input logic            clk,
  input logic            rst,
  alu_exec_stage_if.slave bus
);

  // Reserved parameter; intentionally has no effect on the datapath.
  if (RESET_PC_UNUSED != 0) begin : g_reserved
  end

  logic [5:0]  opcode, funct;
  logic [4:0]  rs_field, rt_field, rd_field, shamt;
  logic [15:0] imm16;
  logic [31:0] imm_sext, imm_ext, op_a, op_b, sum, diff, link;
  logic        ovf_add, ovf_sub, squash;
  logic [4:0]  dest_sel;
  logic        br_taken;
  logic [31:0] br_target;

  assign opcode   = bus.inst[31:26];
  assign rs_field = bus.inst[25:21];
  assign rt_field = bus.inst[20:16];
  assign rd_field = bus.inst[15:11];
  assign shamt    = bus.inst[10:6];
  assign funct    = bus.inst[5:0];
  assign imm16    = bus.inst[15:0];
  assign squash   = bus.br_late_done;

  assign imm_sext = sext16(imm16);
  assign imm_ext  = (opcode inside {OP_ANDI, OP_ORI, OP_XORI}) ? {16'd0, imm16} : imm_sext;
  assign op_a     = bus.const_override_rs ? {27'd0, shamt} : bus.rs_val;
  assign op_b     = bus.const_override_rt ? imm_ext : bus.rt_val;
  assign sum      = op_a + op_b;
  assign diff     = op_a - op_b;
  assign ovf_add  = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
  assign ovf_sub  = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
  assign link     = bus.pc + 32'd8;
  assign dest_sel = bus.rt_override_rd ? rt_field :
                    bus.rs_override_rd ? rs_field : rd_field;

  alu_branch_unit u_branch (
    .opcode   (opcode),
    .funct    (funct),
    .rt_field (rt_field),
    .imm      (imm16),
    .pc       (bus.pc),
    .rs_val   (bus.rs_val),
    .rt_val   (bus.rt_val),
    .taken    (br_taken),
    .target   (br_target)
  );

  logic [31:0] value_next;
  logic        writes_next;
  logic [4:0]  dest_next;
  exc_t        exc_next;
  logic [5:0]  la_op_next;
  logic        la_en_next;

  always_comb begin
    value_next  = 32'd0;
    writes_next = 1'b0;
    dest_next   = dest_sel;
    exc_next    = EXC_NONE;
    la_op_next  = LA_NONE;
    la_en_next  = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        writes_next = 1'b1;
        case (funct)
          FN_SLL, FN_SLLV: value_next = op_b << op_a[4:0];
          FN_SRL, FN_SRLV: value_next = op_b >> op_a[4:0];
          FN_SRA, FN_SRAV: value_next = $signed(op_b) >>> op_a[4:0];
          FN_JR:           writes_next = 1'b0;
          FN_JALR:         value_next = link;
          FN_SYSCALL:      exc_next = EXC_SYSCALL;
          FN_BREAK:        exc_next = EXC_BREAK;
          FN_MFHI:         value_next = bus.latealu_hi;
          FN_MFLO:         value_next = bus.latealu_lo;
          FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU: begin
            writes_next = 1'b0;
            la_op_next  = funct;
          end
          FN_ADD: begin
            value_next = sum;
            if (ovf_add) exc_next = EXC_OVF;
          end
          FN_ADDU: value_next = sum;
          FN_SUB: begin
            value_next = diff;
            if (ovf_sub) exc_next = EXC_OVF;
          end
          FN_SUBU: value_next = diff;
          FN_AND:  value_next = op_a & op_b;
          FN_OR:   value_next = op_a | op_b;
          FN_XOR:  value_next = op_a ^ op_b;
          FN_NOR:  value_next = ~(op_a | op_b);
          FN_SLT:  value_next = {31'd0, $signed(op_a) < $signed(op_b)};
          FN_SLTU: value_next = {31'd0, op_a < op_b};
          default: exc_next = EXC_RI;
        endcase
      end
      OP_JAL: begin
        writes_next = 1'b1;
        dest_next   = 5'd31;
        value_next  = link;
      end
      OP_ADDI: begin
        writes_next = 1'b1;
        value_next  = sum;
        if (ovf_add) exc_next = EXC_OVF;
      end
      OP_ADDIU: begin writes_next = 1'b1; value_next = sum; end
      OP_SLTI:  begin writes_next = 1'b1; value_next = {31'd0, $signed(op_a) < $signed(op_b)}; end
      OP_SLTIU: begin writes_next = 1'b1; value_next = {31'd0, op_a < op_b}; end
      OP_ANDI:  begin writes_next = 1'b1; value_next = op_a & op_b; end
      OP_ORI:   begin writes_next = 1'b1; value_next = op_a | op_b; end
      OP_XORI:  begin writes_next = 1'b1; value_next = op_a ^ op_b; end
      OP_LUI:   begin writes_next = 1'b1; value_next = {imm16, 16'd0}; end
      OP_SPECIAL2: begin
        if (funct == FN2_MUL) begin
          writes_next = 1'b1;
          la_op_next  = LA_MUL;
          la_en_next  = 1'b1;
        end
      end
      default: begin
        // Memory ops always present the effective address; only loads write back.
        if (is_load(opcode) || is_store(opcode)) value_next = bus.rs_val + imm_sext;
        if (is_load(opcode)) begin
          writes_next = 1'b1;
          dest_next   = rt_field;
        end
      end
    endcase
    if (exc_next != EXC_NONE) writes_next = 1'b0;
  end

  logic [4:0]  rd_index_reg;
  logic [31:0] rd_value_reg;
  logic        br_en_reg;
  logic [31:0] br_target_reg;
  logic        memop_dis_reg;
  logic        early_exc_dis_reg;
  logic        la_en_reg;
  logic [5:0]  la_op_reg;
  logic [31:0] la_a0_reg, la_a1_reg;
  exc_t        exc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_index_reg      <= 5'd0;
      rd_value_reg      <= 32'd0;
      br_en_reg         <= 1'b0;
      br_target_reg     <= 32'd0;
      memop_dis_reg     <= 1'b0;
      early_exc_dis_reg <= 1'b0;
      la_en_reg         <= 1'b0;
      la_op_reg         <= LA_NONE;
      la_a0_reg         <= 32'd0;
      la_a1_reg         <= 32'd0;
      exc_reg           <= EXC_NONE;
    end else begin
      rd_index_reg      <= (writes_next && !squash) ? dest_next : 5'd0;
      rd_value_reg      <= value_next;
      br_en_reg         <= br_taken && !squash;
      br_target_reg     <= br_target;
      memop_dis_reg     <= squash || (exc_next != EXC_NONE);
      early_exc_dis_reg <= squash;
      la_en_reg         <= la_en_next && !squash;
      la_op_reg         <= squash ? LA_NONE : la_op_next;
      la_a0_reg         <= bus.rs_val;
      la_a1_reg         <= bus.rt_val;
      exc_reg           <= squash ? EXC_NONE : exc_next;
    end
  end

  assign bus.rd_index                = rd_index_reg;
  assign bus.rd_value                = rd_value_reg;
  assign bus.br_late_enable          = br_en_reg;
  assign bus.br_late_target          = br_target_reg;
  assign bus.memop_disable           = memop_dis_reg;
  assign bus.early_exception_disable = early_exc_dis_reg;
  assign bus.latealu_enable          = la_en_reg;
  assign bus.latealu_op              = la_op_reg;
  assign bus.latealu_a0              = la_a0_reg;
  assign bus.latealu_a1              = la_a1_reg;
  assign bus.exception               = exc_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: directed vectors push expectations, a monitor pops and compares.
module tb_alu_exec_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_stage_if bus ();

  alu_exec_stage #(.RESET_PC_UNUSED(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam int K_RDI = 0, K_RDV = 1, K_BRE = 2, K_BRT = 3, K_MEM = 4, K_EED = 5;
  localparam int K_LAE = 6, K_LAO = 7, K_A0 = 8, K_A1 = 9, K_EXC = 10;
  localparam logic [10:0] C_ALL  = 11'h7FF;
  localparam logic [10:0] C_BASE = 11'h4F5;
  localparam logic [10:0] C_RDV  = 11'h002;
  localparam logic [10:0] C_BRT  = 11'h008;
  localparam logic [10:0] C_ARGS = 11'h300;

  typedef struct {
    string       name;
    logic [10:0] care;
    logic [4:0]  rd_index;
    logic [31:0] rd_value;
    logic        br_en;
    logic [31:0] br_tgt;
    logic        memop;
    logic        eed;
    logic        la_en;
    logic [5:0]  la_op;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [2:0]  exc;
  } exp_t;

  exp_t sb_q[$];
  logic tb_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input string name, input logic [10:0] care,
                              input logic [4:0] rdi, input logic [31:0] rdv,
                              input logic bre, input logic [31:0] brt,
                              input logic mem, input logic eed,
                              input logic lae, input logic [5:0] lao,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [2:0] exc);
    exp_t e;
    e.name = name; e.care = care; e.rd_index = rdi; e.rd_value = rdv;
    e.br_en = bre; e.br_tgt = brt; e.memop = mem; e.eed = eed;
    e.la_en = lae; e.la_op = lao; e.a0 = a0; e.a1 = a1; e.exc = exc;
    return e;
  endfunction

  // flags = {const_override_rs, const_override_rt, rs_override_rd, rt_override_rd, br_late_done}
  task automatic issue(input logic r, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] flags,
                       input logic [31:0] hi, input exp_t e);
    @(negedge clk);
    rst                   = r;
    bus.inst              = inst;
    bus.pc                = pc;
    bus.rs_val            = rs;
    bus.rt_val            = rt;
    bus.const_override_rs = flags[4];
    bus.const_override_rt = flags[3];
    bus.rs_override_rd    = flags[2];
    bus.rt_override_rd    = flags[1];
    bus.br_late_done      = flags[0];
    bus.latealu_hi        = hi;
    bus.latealu_lo        = 32'h1234_5678;
    tb_valid              = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string txn, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", txn, field, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic take;
    int   err0;
    forever begin
      @(posedge clk);
      take = tb_valid;
      @(negedge clk);
      if (take) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=0 entries expected>=1");
        end else begin
          e = sb_q.pop_front();
          err0 = errors;
          if (e.care[K_RDI]) chk(e.name, "rd_index", 32'(bus.rd_index), 32'(e.rd_index));
          if (e.care[K_RDV]) chk(e.name, "rd_value", bus.rd_value, e.rd_value);
          if (e.care[K_BRE]) chk(e.name, "br_late_enable", 32'(bus.br_late_enable), 32'(e.br_en));
          if (e.care[K_BRT]) chk(e.name, "br_late_target", bus.br_late_target, e.br_tgt);
          if (e.care[K_MEM]) chk(e.name, "memop_disable", 32'(bus.memop_disable), 32'(e.memop));
          if (e.care[K_EED]) chk(e.name, "early_exc_disable", 32'(bus.early_exception_disable), 32'(e.eed));
          if (e.care[K_LAE]) chk(e.name, "latealu_enable", 32'(bus.latealu_enable), 32'(e.la_en));
          if (e.care[K_LAO]) chk(e.name, "latealu_op", 32'(bus.latealu_op), 32'(e.la_op));
          if (e.care[K_A0])  chk(e.name, "latealu_a0", bus.latealu_a0, e.a0);
          if (e.care[K_A1])  chk(e.name, "latealu_a1", bus.latealu_a1, e.a1);
          if (e.care[K_EXC]) chk(e.name, "exception", 32'(bus.exception), 32'(e.exc));
          $display("txn %s: %0d field errors", e.name, errors - err0);
        end
      end
    end
  end

  initial begin : stimulus
    bus.inst = '0; bus.pc = '0; bus.rs_val = '0; bus.rt_val = '0;
    bus.const_override_rs = 1'b0; bus.const_override_rt = 1'b0;
    bus.rs_override_rd = 1'b0; bus.rt_override_rd = 1'b0; bus.br_late_done = 1'b0;
    bus.latealu_hi = '0; bus.latealu_lo = '0;

    issue(1'b1, 32'h0022_1821, 32'h0, 32'hFFFF_FFFF, 32'h1, 5'b00000, 32'h0,
          mk("reset", C_ALL, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h2025_0020, 32'h0, 32'h7FFF_FFF0, 32'h0, 5'b01010, 32'h0,
          mk("addi_ovf", C_BASE, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd1));
    issue(1'b0, 32'h0022_1821, 32'h0, 32'hFFFF_FFFF, 32'h1, 5'b00000, 32'h0,
          mk("addu_wrap", C_BASE | C_RDV, 5'd3, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h1022_FFFF, 32'h100, 32'h55, 32'h55, 5'b00000, 32'h0,
          mk("beq_taken", C_BASE | C_BRT, 5'd0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h1022_FFFF, 32'h100, 32'h55, 32'h56, 5'b00000, 32'h0,
          mk("beq_not_taken", C_BASE, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h0020_F809, 32'h200, 32'h400, 32'h0, 5'b00000, 32'h0,
          mk("jalr", C_BASE | C_RDV | C_BRT, 5'd31, 32'h208, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h8C24_FFFC, 32'h0, 32'h1000, 32'h0, 5'b01010, 32'h0,
          mk("lw", C_BASE | C_RDV, 5'd4, 32'hFFC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h8C24_FFFC, 32'h0, 32'h1000, 32'h0, 5'b01011, 32'h0,
          mk("lw_squash", C_BASE, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h0022_0018, 32'h0, 32'h3, 32'h5, 5'b00000, 32'h0,
          mk("mult", C_BASE | C_ARGS, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h18, 32'h3, 32'h5, 3'd0));
    issue(1'b1, 32'h0022_0018, 32'h0, 32'h3, 32'h5, 5'b00000, 32'h0,
          mk("mult_rst", C_ALL, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h0022_302A, 32'h0, 32'hFFFF_FFFF, 32'h1, 5'b00000, 32'h0,
          mk("slt_signed", C_BASE | C_RDV, 5'd6, 32'h1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h0022_302B, 32'h0, 32'hFFFF_FFFF, 32'h1, 5'b00000, 32'h0,
          mk("sltu_unsigned", C_BASE | C_RDV, 5'd6, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h0002_3903, 32'h0, 32'h0, 32'h8000_0000, 5'b10000, 32'h0,
          mk("sra_shamt4", C_BASE | C_RDV, 5'd7, 32'hF800_0000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h3425_8000, 32'h0, 32'h1, 32'h0, 5'b01010, 32'h0,
          mk("ori_zext", C_BASE | C_RDV, 5'd5, 32'h0000_8001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b0, 32'h0000_000C, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0,
          mk("syscall", C_BASE, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd2));
    issue(1'b0, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 5'b00000, 32'h0,
          mk("unknown_funct", C_BASE, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd4));
    issue(1'b0, 32'h7022_1802, 32'h0, 32'h6, 32'h7, 5'b00000, 32'h0,
          mk("mul", C_BASE | C_ARGS, 5'd3, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 6'h02, 32'h6, 32'h7, 3'd0));
    issue(1'b0, 32'h0000_4010, 32'h0, 32'h0, 32'h0, 5'b00000, 32'hDEAD_BEEF,
          mk("mfhi", C_BASE | C_RDV, 5'd8, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));
    issue(1'b1, 32'h8C24_FFFC, 32'h0, 32'h1000, 32'h0, 5'b01011, 32'h0,
          mk("rst_and_squash", C_ALL, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 3'd0));

    @(negedge clk);
    tb_valid = 1'b0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
